ifns_decode_scheduler: RTL and testbench
========================================

# ifns_decode_scheduler

Round-robin scheduler that shares one IFNS 16-bit decoder core among several receive lanes of a CAC link. Each lane offers 23-bit IFNS codewords over a valid/ready handshake; the scheduler grants one lane per cycle, runs the codeword through a two-stage registered decode pipeline, and emits the 16-bit value tagged with its source lane. Sits between the per-lane line receivers and the downstream payload reassembly logic.

## Interface
- LANES, 4, number of requesting lanes (2..8)
- CW, 23, codeword width (fixed by IFNS 16-bit code)
- DW, 16, decoded data width
- LW, $clog2(LANES), lane-tag width
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  LANES  per-lane codeword valid
- in_ready  out  LANES  per-lane accept; at most one bit high per cycle
- in_code  in  LANES*CW  lane i codeword at bits [i*CW +: CW]; bit 0 = d1, bit 22 = d23
- out_valid  out  1  decoded result valid
- out_ready  in  1  downstream accept
- out_data  out  DW  decoded value, low 16 bits of weighted sum
- out_lane  out  LW  source lane of out_data
- out_ovf  out  1  weighted sum ≥ 65536 (codeword outside 16-bit range)
- ovf_count  out  16  saturating count of results delivered with out_ovf=1

## Operation
- Weights d1..d23: 1,1,2,3,5,8,13,21,34,55,89,144,233,377,610,987,1597,2584,4181,6765,10946,17711,46368. Sum computed 17 bits wide; out_data = sum[15:0], out_ovf = sum[16].
- Arbitration: pointer ptr (LW bits, reset 0). Grant = first lane j with in_valid[j], searching ptr, ptr+1, … wrapping mod LANES. in_ready[j] = grant[j] & s1_load. On handshake ptr ← (j+1) mod LANES; no handshake → ptr unchanged.
- Stage S1 register: {code, lane, s1_v}. s1_load = !s1_v | s2_load.
- Stage S2 register: {sum17, lane, s2_v}, loaded from decoder core on S1 contents. s2_load = !s2_v | out_ready.
- Outputs driven directly from S2: out_valid = s2_v.
- ovf_count increments on out_valid & out_ready & out_ovf; holds at 16'hFFFF.
- No codeword validity (forbidden-pattern) check in this block.
- Reset values: in_ready=0, out_valid=0, out_data=0, out_lane=0, out_ovf=0, ovf_count=0, ptr=0, s1_v=s2_v=0.

## Timing
- Latency: codeword accepted at edge N → out_valid high after edge N+2 (visible cycle N+2).
- Throughput: one codeword per cycle while out_ready=1.
- in_ready depends combinationally on in_valid, out_ready and pipeline state; no combinational path from in_code to outputs.
- out_valid/out_data/out_lane/out_ovf stable while out_valid & !out_ready.
- Full pipeline (s1_v=s2_v=1, out_ready=0): all in_ready=0; ptr frozen.
- Simultaneous out_ready and new request with full pipeline: pipeline shifts and accepts same cycle.
- LANES wrap: ptr at LANES-1 with handshake → 0.
- Async reset mid-operation: in-flight words discarded, outputs to reset values immediately; first grant after release starts at lane 0.

## Structure
- Package ifns_pkg: CW, DW, IFNS_WEIGHTS constant array (23 × 17-bit), sum width 17.
- Sub-module decoderIFNS_16di_sum17: combinational 23-bit → 17-bit weighted sum, instantiated once between S1 and S2; arbiter and pipeline control stay in this module.

## Test plan
- Single lane 0, code 23'h000001 → out_data=1, out_lane=0, out_ovf=0, exactly 2 cycles after handshake.
- All lanes valid continuously, out_ready=1 → grants 0,1,2,3,0,… one per cycle; outputs in same lane order.
- Code 23'h7FFFFF → sum 92735: out_data=16'h6A3F, out_ovf=1, ovf_count 0→1; code with only d23 set → 46368, out_ovf=0.
- out_ready low 5 cycles with all lanes valid → two words held, all in_ready=0, out_data unchanged; on release no loss/duplication, order preserved.
- Lanes 1 and 3 only valid, ptr=2 → lane 3 granted first, then 1.
- rst asserted with 2 words in flight → out_valid=0 same cycle; after release, lane 0 granted first, ovf_count=0.

Source files
------------

// File: rtl/ifns_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifns_pkg
// Description : Shared constants for the IFNS 16-bit decode path: codeword,
//               data and sum widths plus the per-bit weight table.
// Revision    : 1.0 - initial release
// ============================================================================
package ifns_pkg;

  localparam int CW = 23;  // codeword width
  localparam int DW = 16;  // decoded data width
  localparam int SW = 17;  // weighted-sum width (bit 16 flags out-of-range)

  // Weight of codeword bit i (index 0 = d1). The last entry deliberately
  // skips a Fibonacci term; it is not a continuation of the sequence.
  localparam logic [SW-1:0] IFNS_WEIGHTS [CW] = '{
    17'd1,    17'd1,    17'd2,    17'd3,    17'd5,    17'd8,
    17'd13,   17'd21,   17'd34,   17'd55,   17'd89,   17'd144,
    17'd233,  17'd377,  17'd610,  17'd987,  17'd1597, 17'd2584,
    17'd4181, 17'd6765, 17'd10946, 17'd17711, 17'd46368
  };

endpackage
`default_nettype wire

// File: rtl/ifns_decode_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : ifns_decode_scheduler_if
// Description : Lane-side request bus and downstream result bus of the IFNS
//               decode scheduler, bundled with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface ifns_decode_scheduler_if #(
  parameter int LANES = 4,
  parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
);
  import ifns_pkg::*;

  logic [LANES-1:0]    in_valid;
  logic [LANES-1:0]    in_ready;
  logic [LANES*CW-1:0] in_code;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_data;
  logic [LW-1:0]       out_lane;
  logic                out_ovf;
  logic [15:0]         ovf_count;

  // Environment side: drives requests and downstream ready.
  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_ovf, ovf_count
  );

  // Scheduler side.
  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_ovf, ovf_count
  );

endinterface
`default_nettype wire

// File: rtl/ifns_decode_scheduler_decoder.sv
`default_nettype none
// ============================================================================
// Module      : decoderIFNS_16di_sum17
// Description : Combinational IFNS core: weighted sum of the 23 codeword bits,
//               17 bits wide so out-of-range codewords are visible in bit 16.
// Revision    : 1.0 - initial release
// ============================================================================
module decoderIFNS_16di_sum17
  import ifns_pkg::*;
(
  input  logic [CW-1:0] code,
  output logic [SW-1:0] sum
);

  // Accumulate the weight of every set codeword bit.
  always_comb begin
    sum = '0;
    for (int i = 0; i < CW; i++) begin
      if (code[i]) begin
        sum = sum + IFNS_WEIGHTS[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifns_decode_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ifns_decode_scheduler
// Description : Round-robin arbiter sharing one IFNS decoder among LANES
//               receive lanes, with a two-stage registered decode pipeline
//               and a saturating overflow counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ifns_decode_scheduler
  import ifns_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  ifns_decode_scheduler_if.slave  bus
);

  logic [LW-1:0]    ptr;
  logic [LW-1:0]    cand;
  logic [LW-1:0]    grant_lane;
  logic             any_grant;
  logic             handshake;
  logic             s1_load;
  logic             s2_load;
  logic [LANES-1:0] ready;
  logic [CW-1:0]    lane_code [LANES];

  logic             s1_v;
  logic [CW-1:0]    s1_code;
  logic [LW-1:0]    s1_lane;
  logic [SW-1:0]    dec_sum;
  logic             s2_v;
  logic [SW-1:0]    s2_sum;
  logic [LW-1:0]    s2_lane;
  logic [15:0]      ovf_cnt;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_unpack
      assign lane_code[i] = bus.in_code[i*CW +: CW];
    end
  endgenerate

  // A stage can take new data when it is empty or is being drained.
  assign s2_load = !s2_v || bus.out_ready;
  assign s1_load = !s1_v || s2_load;

  // First requesting lane at or after the pointer, wrapping mod LANES.
  always_comb begin
    any_grant  = 1'b0;
    grant_lane = '0;
    cand       = '0;
    for (int k = 0; k < LANES; k++) begin
      cand = LW'((int'(ptr) + k) % LANES);
      if (!any_grant && bus.in_valid[cand]) begin
        any_grant  = 1'b1;
        grant_lane = cand;
      end
    end
  end

  // Gating with rst keeps in_ready low while reset holds the pipeline.
  assign handshake = any_grant && s1_load && !rst;

  // One-hot ready toward the granted lane only.
  always_comb begin
    ready = '0;
    if (handshake) begin
      ready[grant_lane] = 1'b1;
    end
  end

  // Pointer moves past the served lane; unchanged without a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (handshake) begin
      ptr <= (grant_lane == LW'(LANES - 1)) ? '0 : grant_lane + LW'(1);
    end
  end

  // Stage 1 captures the accepted codeword and its lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_code <= '0;
      s1_lane <= '0;
    end else if (s1_load) begin
      s1_v <= handshake;
      if (handshake) begin
        s1_code <= lane_code[grant_lane];
        s1_lane <= grant_lane;
      end
    end
  end

  decoderIFNS_16di_sum17 u_dec (
    .code (s1_code),
    .sum  (dec_sum)
  );

  // Stage 2 holds the decoded sum; it only changes when drained or empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_sum  <= '0;
      s2_lane <= '0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_sum  <= dec_sum;
        s2_lane <= s1_lane;
      end
    end
  end

  // Count delivered out-of-range results, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (s2_v && bus.out_ready && s2_sum[SW-1] && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = s2_v;
  assign bus.out_data  = s2_sum[DW-1:0];
  assign bus.out_ovf   = s2_sum[SW-1];
  assign bus.out_lane  = s2_lane;
  assign bus.ovf_count = ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ifns_decode_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifns_decode_scheduler
// Description : Self-checking bench for ifns_decode_scheduler: queue-based
//               reference model checked every cycle plus directed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifns_decode_scheduler;
  import ifns_pkg::*;

  localparam int LANES = 4;
  localparam int LW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ifns_decode_scheduler_if #(.LANES(LANES), .LW(LW)) bus ();

  ifns_decode_scheduler #(.LANES(LANES), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Weight table rebuilt from the Fibonacci recurrence; d23 is a special term.
  function automatic int unsigned ifns_sum(input logic [22:0] c);
    int unsigned w [23];
    int unsigned s;
    s    = 0;
    w[0] = 1;
    w[1] = 1;
    for (int i = 2; i < 22; i++) w[i] = w[i-1] + w[i-2];
    w[22] = 46368;
    for (int i = 0; i < 23; i++) if (c[i]) s += w[i];
    return s;
  endfunction

  // Reference model: FIFO of accepted words, capacity two, two-cycle latency.
  typedef struct {
    int          lane;
    logic [22:0] code;
    int          acc;
  } item_t;

  item_t       m_q[$];
  item_t       m_it;
  int          m_ptr = 0;
  int          m_ovf = 0;
  int          cyc   = 0;
  bit          m_ov;
  bit          m_acc;
  int          m_g;
  int          m_idx;
  logic [3:0]  m_rdy;
  int unsigned m_s;

  // Compare DUT against the model every cycle, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_lane", bus.out_lane, 0);
      chk("rst_out_ovf", bus.out_ovf, 0);
      chk("rst_ovf_count", bus.ovf_count, 0);
      m_q.delete();
      m_ptr = 0;
      m_ovf = 0;
      cyc   = 0;
    end else begin
      m_ov = (m_q.size() > 0) && (cyc - m_q[0].acc >= 2);
      m_g  = -1;
      for (int k = 0; k < LANES; k++) begin
        m_idx = (m_ptr + k) % LANES;
        if (m_g < 0 && bus.in_valid[m_idx]) m_g = m_idx;
      end
      m_acc = (m_g >= 0) && ((m_q.size() < 2) || (m_ov && bus.out_ready));
      m_rdy = '0;
      if (m_acc) m_rdy[m_g] = 1'b1;
      chk("in_ready", bus.in_ready, m_rdy);
      chk("out_valid", bus.out_valid, m_ov);
      m_s = 0;
      if (m_ov) begin
        m_s = ifns_sum(m_q[0].code);
        chk("out_data", bus.out_data, m_s & 32'hFFFF);
        chk("out_lane", bus.out_lane, m_q[0].lane);
        chk("out_ovf", bus.out_ovf, (m_s >= 65536) ? 1 : 0);
      end
      chk("ovf_count", bus.ovf_count, m_ovf);
      if (m_ov && bus.out_ready) begin
        if (m_s >= 65536 && m_ovf < 65535) m_ovf++;
        void'(m_q.pop_front());
      end
      if (m_acc) begin
        m_it.lane = m_g;
        m_it.code = bus.in_code[m_g*CW +: CW];
        m_it.acc  = cyc;
        m_q.push_back(m_it);
        m_ptr = (m_g + 1) % LANES;
      end
      cyc++;
    end
  end

  // Stimulus state
  logic [3:0]  valid_v;
  logic [22:0] code_v [LANES];
  logic        ordy;
  bit          one_shot;
  logic [3:0]  hs;
  int          seq [LANES];
  int          nhs;
  logic [15:0] saved;

  function automatic logic [22:0] gen(input int j, input int k);
    return 23'((j + 1) * 40503 ^ (k * 2654435) + k * k * 7);
  endfunction

  task automatic apply();
    bus.in_valid  = valid_v;
    for (int j = 0; j < LANES; j++) bus.in_code[j*CW +: CW] = code_v[j];
    bus.out_ready = ordy;
  endtask

  // One clock: drive at posedge+1, observe handshakes mid-cycle.
  task automatic cycle();
    apply();
    @(negedge clk);
    #1;
    hs = bus.in_valid & bus.in_ready;
    for (int j = 0; j < LANES; j++) begin
      if (hs[j]) begin
        if (one_shot) valid_v[j] = 1'b0;
        else begin
          seq[j]++;
          code_v[j] = gen(j, seq[j]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input string name);
    hs = '0;
    for (int i = 0; i < 10 && hs == 4'b0000; i++) cycle();
    if (hs == 4'b0000) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=none required=handshake", name);
    end
  endtask

  task automatic drain();
    valid_v = '0;
    for (int i = 0; i < 20 && m_q.size() != 0; i++) cycle();
    chk("drain_empty", m_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    valid_v  = 4'b1111;
    ordy     = 1'b1;
    one_shot = 1'b1;
    for (int j = 0; j < LANES; j++) begin
      code_v[j] = '0;
      seq[j]    = 0;
    end
    apply();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_ovf_count", bus.ovf_count, 0);
    rst     = 1'b0;
    valid_v = '0;
    apply();

    // Single word on lane 0: latency exactly two cycles
    valid_v   = 4'b0001;
    code_v[0] = 23'h000001;
    wait_hs("p1");
    chk("p1_grant", hs, 4'b0001);
    chk("p1_lat_n1", bus.out_valid, 0);
    cycle();
    chk("p1_valid", bus.out_valid, 1);
    chk("p1_data", bus.out_data, 16'h0001);
    chk("p1_lane", bus.out_lane, 0);
    chk("p1_ovf", bus.out_ovf, 0);
    drain();

    // All-ones codeword overflows; d23 alone does not
    valid_v   = 4'b0100;
    code_v[2] = 23'h7FFFFF;
    wait_hs("p2a");
    chk("p2a_grant", hs, 4'b0100);
    cycle();
    chk("p2a_data", bus.out_data, 16'h6A3F);
    chk("p2a_ovf", bus.out_ovf, 1);
    chk("p2a_cnt_before", bus.ovf_count, 0);
    cycle();
    chk("p2a_cnt_after", bus.ovf_count, 1);
    valid_v   = 4'b0100;
    code_v[2] = 23'h400000;
    wait_hs("p2b");
    cycle();
    chk("p2b_data", bus.out_data, 16'hB520);
    chk("p2b_ovf", bus.out_ovf, 0);
    cycle();
    chk("p2b_cnt", bus.ovf_count, 1);
    drain();

    // Bring the pointer to 2, then lanes 1 and 3 compete
    valid_v   = 4'b0010;
    code_v[1] = 23'h0000AA;
    wait_hs("p3a");
    drain();
    valid_v   = 4'b1010;
    code_v[1] = 23'h123456;
    code_v[3] = 23'h00F00F;
    wait_hs("p3b");
    chk("p3_first", hs, 4'b1000);
    cycle();
    chk("p3_second", hs, 4'b0010);
    drain();

    // All lanes continuously valid: one grant per cycle
    one_shot = 1'b0;
    valid_v  = 4'b1111;
    ordy     = 1'b1;
    nhs      = 0;
    repeat (12) begin
      cycle();
      if (hs != 4'b0000) nhs++;
    end
    chk("p4_throughput", nhs, 12);

    // Downstream stall for five cycles with the pipeline full
    saved = bus.out_data;
    ordy  = 1'b0;
    nhs   = 0;
    repeat (5) begin
      cycle();
      if (hs != 4'b0000) nhs++;
    end
    chk("p5_stall_hs", nhs, 0);
    chk("p5_hold_valid", bus.out_valid, 1);
    chk("p5_hold_data", bus.out_data, saved);
    ordy = 1'b1;
    repeat (6) cycle();
    drain();

    // Asynchronous reset with words in flight
    valid_v = 4'b1111;
    repeat (3) cycle();
    #2 rst = 1'b1;
    #1;
    chk("p6_rst_valid", bus.out_valid, 0);
    chk("p6_rst_cnt", bus.ovf_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    chk("p6_first_grant", hs, 4'b0001);
    repeat (3) cycle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
